vga_stream_out: RTL and testbench



---
 rtl/vga_stream_pkg.sv | 47 ++++
 rtl/vga_timing_gen.sv | 73 +++++++
 rtl/vga_stream_out.sv | 169 ++++++++++++++++
 tb/tb_vga_stream_out.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_stream_pkg
// Brief    : Shared timing defaults (640x480@60), FSM state type, pixel type
//            and colour-bar lookup for the VGA stream output stage.
// Revision : 1.0 - initial release
// ============================================================================
package vga_stream_pkg;

  localparam int C_H_ACTIVE = 640;
  localparam int C_H_FP     = 16;
  localparam int C_H_SYNC   = 96;
  localparam int C_H_BP     = 48;
  localparam int C_V_ACTIVE = 480;
  localparam int C_V_FP     = 10;
  localparam int C_V_SYNC   = 2;
  localparam int C_V_BP     = 33;
  localparam int C_CB       = 8;

  typedef enum logic [0:0] {
    SEEK = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [C_CB-1:0] r;
    logic [C_CB-1:0] g;
    logic [C_CB-1:0] b;
  } pixel_t;

  // {r,g,b} on/off for colour bar idx: white, yellow, cyan, green,
  // magenta, red, blue, black
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Free-running VGA raster counters. Line/frame order is active,
//            front porch, sync, back porch. Outputs are combinational
//            decodes of the current counter position.
//            VGA_STREAM_OUT_TEST_PATTERN_EN exposes h_cnt for colour bars.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_stream_pkg::*;
#(
  parameter int H_ACTIVE = C_H_ACTIVE,
  parameter int H_FP     = C_H_FP,
  parameter int H_SYNC   = C_H_SYNC,
  parameter int H_BP     = C_H_BP,
  parameter int V_ACTIVE = C_V_ACTIVE,
  parameter int V_FP     = C_V_FP,
  parameter int V_SYNC   = C_V_SYNC,
  parameter int V_BP     = C_V_BP,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int H_W     = $clog2(H_TOTAL),
  localparam int V_W     = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           reset,
  output logic           active,
  output logic           hs_n,
  output logic           vs_n,
  output logic           origin
`ifdef VGA_STREAM_OUT_TEST_PATTERN_EN
  ,
  output logic [H_W-1:0] h_cnt
`endif
);

  localparam logic [H_W-1:0] C_H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] C_H_ACT      = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] C_HS_START   = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] C_HS_END     = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] C_V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] C_V_ACT      = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] C_VS_START   = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] C_VS_END     = V_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_W-1:0] r_h_cnt;
  logic [V_W-1:0] r_v_cnt;

  // Horizontal counter wraps each line; vertical advances on that wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == C_H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign active = (r_h_cnt < C_H_ACT) && (r_v_cnt < C_V_ACT);
  assign hs_n   = !((r_h_cnt >= C_HS_START) && (r_h_cnt < C_HS_END));
  assign vs_n   = !((r_v_cnt >= C_VS_START) && (r_v_cnt < C_VS_END));
  assign origin = (r_h_cnt == '0) && (r_v_cnt == '0);

`ifdef VGA_STREAM_OUT_TEST_PATTERN_EN
  assign h_cnt = r_h_cnt;
`endif

endmodule
`default_nettype wire

// File: rtl/vga_stream_out.sv
`default_nettype none
// ============================================================================
// Module   : vga_stream_out
// Brief    : Avalon-ST RGB stream to VGA DAC output stage. Locks to the
//            upstream SOP at frame origin, blacks out underflowed pixels and
//            drops back to seeking on framing errors. All DAC outputs are
//            registered one cycle after the raster position.
//            Optional macro VGA_STREAM_OUT_TEST_PATTERN_EN adds test_en for
//            eight vertical colour bars.
// Revision : 1.0 - initial release
// ============================================================================
module vga_stream_out
  import vga_stream_pkg::*;
#(
  parameter int H_ACTIVE = C_H_ACTIVE,
  parameter int H_FP     = C_H_FP,
  parameter int H_SYNC   = C_H_SYNC,
  parameter int H_BP     = C_H_BP,
  parameter int V_ACTIVE = C_V_ACTIVE,
  parameter int V_FP     = C_V_FP,
  parameter int V_SYNC   = C_V_SYNC,
  parameter int V_BP     = C_V_BP,
  parameter int CB       = C_CB
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3*CB-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sop,
  input  logic          in_eop,
`ifdef VGA_STREAM_OUT_TEST_PATTERN_EN
  input  logic          test_en,
`endif
  output logic [CB-1:0] vga_r,
  output logic [CB-1:0] vga_g,
  output logic [CB-1:0] vga_b,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_blank_n,
  output logic          vga_sync_n,
  output logic          underflow,
  output logic          frame_start
);

  localparam int H_W = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);

  logic w_active, w_hs_n, w_vs_n, w_origin, w_test;
  logic w_ready, w_take, w_under, w_frame;
  logic [3*CB-1:0] w_rgb_next;
  state_t r_state, w_next_state;

  logic [3*CB-1:0] r_rgb;
  logic r_hs, r_vs, r_blank_n, r_underflow, r_frame_start;

  // End-of-packet carries no control meaning here
  logic w_unused_eop;
  assign w_unused_eop = in_eop;

`ifdef VGA_STREAM_OUT_TEST_PATTERN_EN
  logic [H_W-1:0] w_h_cnt;
  logic [2:0]     w_bar;
`endif

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk    (clk),
    .reset  (reset),
    .active (w_active),
    .hs_n   (w_hs_n),
    .vs_n   (w_vs_n),
    .origin (w_origin)
`ifdef VGA_STREAM_OUT_TEST_PATTERN_EN
    ,
    .h_cnt  (w_h_cnt)
`endif
  );

`ifdef VGA_STREAM_OUT_TEST_PATTERN_EN
  assign w_test = test_en;
  assign w_bar  = bar_rgb(3'(int'(w_h_cnt) / (H_ACTIVE / 8)));
`else
  assign w_test = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SEEK;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and handshake. A held SOP beat at the origin is displayed
  // in that same cycle, so SEEK behaves as RUN at the locking position.
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_take       = 1'b0;
    w_under      = 1'b0;
    w_frame      = 1'b0;
    if (w_test) begin
      w_next_state = SEEK;
    end else if ((r_state == RUN) || (w_origin && in_valid && in_sop)) begin
      // Framing error: SOP anywhere but the origin, or no SOP at the origin
      if (in_valid && (w_origin ? !in_sop : (w_active && in_sop))) begin
        w_next_state = SEEK;
      end else begin
        w_next_state = RUN;
        w_ready      = w_active;
        w_take       = w_active && in_valid;
        w_under      = w_active && !in_valid;
        w_frame      = w_origin;
      end
    end else begin
      w_next_state = SEEK;
      w_ready      = !(in_valid && in_sop);
    end
  end

  assign in_ready = w_ready && !reset;

  // Pixel selection: accepted beat, colour bars, or black
  always_comb begin
    w_rgb_next = '0;
    if (w_take) begin
      w_rgb_next = in_data;
    end
`ifdef VGA_STREAM_OUT_TEST_PATTERN_EN
    if (w_test && w_active) begin
      w_rgb_next = {{CB{w_bar[2]}}, {CB{w_bar[1]}}, {CB{w_bar[0]}}};
    end
`endif
  end

  // Output registers: one cycle behind the raster position
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb         <= '0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank_n     <= 1'b0;
      r_underflow   <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_rgb         <= w_rgb_next;
      r_hs          <= w_hs_n;
      r_vs          <= w_vs_n;
      r_blank_n     <= w_active;
      r_underflow   <= r_underflow | w_under;
      r_frame_start <= w_frame;
    end
  end

  assign vga_r       = r_rgb[3*CB-1:2*CB];
  assign vga_g       = r_rgb[2*CB-1:CB];
  assign vga_b       = r_rgb[CB-1:0];
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_blank_n = r_blank_n;
  assign vga_sync_n  = 1'b0;
  assign underflow   = r_underflow;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_stream_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_stream_out
// Brief    : Self-checking bench for vga_stream_out using a reduced raster
//            (16x6 visible, 24x10 total) and a queue-based upstream source.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_stream_out;

  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA = 6,  VFP = 1, VSY = 2, VBP = 1;
  localparam int CB = 8;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic reset;
  logic [3*CB-1:0] in_data;
  logic in_valid, in_ready, in_sop, in_eop;
  logic [CB-1:0] vga_r, vga_g, vga_b;
  logic vga_hs, vga_vs, vga_blank_n, vga_sync_n, underflow, frame_start;

  typedef struct packed {
    logic [3*CB-1:0] data;
    logic            sop;
  } beat_t;

  beat_t src[$];
  int  m_h = 0, m_v = 0;
  bit  m_lock = 0, m_under = 0;
  int  last_h, last_v;
  int  n_fs, n_acc, n_hs_low, n_vs_low;
  int  checks = 0, errors = 0;

  always #5 clk = ~clk;

  vga_stream_out #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .CB(CB)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs),
    .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
    .underflow(underflow), .frame_start(frame_start)
  );

  task automatic push_frame();
    beat_t b;
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        b.data = {8'(x), 8'(y), 8'($urandom)};
        b.sop  = (x == 0) && (y == 0);
        src.push_back(b);
      end
    end
  endtask

  // One pixel clock: drive, check ready, check registered outputs, advance model
  task automatic step(input bit rst, input bit valid_en);
    bit v, s, act, org, err, rdy, take, frm, und;
    logic [3*CB-1:0] d, px;
    logic [29:0] exp_o, got_o;
    @(negedge clk);
    v    = valid_en && (src.size() > 0);
    d    = v ? src[0].data : 24'($urandom);
    s    = v ? src[0].sop  : 1'($urandom_range(0, 1));
    reset    = rst;
    in_valid = v;
    in_data  = d;
    in_sop   = s;
    in_eop   = 1'($urandom_range(0, 1));

    act = (m_h < HA) && (m_v < VA);
    org = (m_h == 0) && (m_v == 0);
    rdy = 0; take = 0; frm = 0; und = 0; err = 0; px = '0;
    if (!rst) begin
      if (m_lock || (org && v && s)) begin
        if (org) err = v && !s;
        else     err = v && act && s;
        rdy  = act && !err;
        take = rdy && v;
        und  = act && !v && !err;
        frm  = org && !err;
        if (take) px = d;
        m_lock = !err;
      end else begin
        rdy  = !(v && s);
        take = rdy && v;
        m_lock = 0;
      end
    end

    #1;
    checks++;
    if (in_ready !== rdy) begin
      errors++;
      $display("FAIL in_ready at (%0d,%0d): got %b want %b", m_h, m_v, in_ready, rdy);
    end
    if (in_valid && in_ready) n_acc++;

    @(posedge clk);
    #1;
    if (rst) begin
      exp_o = {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      m_under = 0;
    end else begin
      m_under = m_under | und;
      exp_o = {px,
               !((m_h >= HA + HFP) && (m_h < HA + HFP + HSY)),
               !((m_v >= VA + VFP) && (m_v < VA + VFP + VSY)),
               act, 1'b0, m_under, frm};
    end
    got_o = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n, underflow, frame_start};
    checks++;
    if (got_o !== exp_o) begin
      errors++;
      $display("FAIL outputs at (%0d,%0d): got %h want %h", m_h, m_v, got_o, exp_o);
    end
    if (frame_start === 1'b1) n_fs++;
    if (vga_hs === 1'b0) n_hs_low++;
    if (vga_vs === 1'b0) n_vs_low++;

    if (take) void'(src.pop_front());
    last_h = rst ? 0 : m_h;
    last_v = rst ? 0 : m_v;
    if (rst) begin
      m_h = 0; m_v = 0; m_lock = 0;
    end else if (m_h == HT - 1) begin
      m_h = 0;
      m_v = (m_v == VT - 1) ? 0 : m_v + 1;
    end else begin
      m_h++;
    end
  endtask

  task automatic run_to(input int h, input int v);
    int n = 0;
    while (!(m_h == h && m_v == v) && n < 2 * FT) begin
      step(0, 1);
      n++;
    end
    if (!(m_h == h && m_v == v)) begin
      errors++;
      $display("FAIL run_to timeout: got (%0d,%0d) want (%0d,%0d)", m_h, m_v, h, v);
    end
  endtask

  task automatic do_reset();
    src.delete();
    step(1, 0);
    step(1, 0);
  endtask

  task automatic clear_stats();
    n_fs = 0; n_acc = 0; n_hs_low = 0; n_vs_low = 0;
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 0; in_sop = 0; in_eop = 0; in_data = '0;
    step(1, 0); step(1, 0); step(1, 0);
    checks++;
    if ({vga_hs, vga_vs, vga_blank_n, underflow, frame_start, in_ready} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_state: got %b want 110000",
               {vga_hs, vga_vs, vga_blank_n, underflow, frame_start, in_ready});
    end
  endtask

  task automatic test_clean_frame();
    bit seen = 0;
    do_reset();
    push_frame(); push_frame(); push_frame();
    clear_stats();
    for (int i = 0; i < 2 * FT; i++) begin
      step(0, 1);
      if (last_h == 5 && last_v == 3 && !seen) begin
        seen = 1;
        checks++;
        if (vga_r !== 8'd5 || vga_g !== 8'd3) begin
          errors++;
          $display("FAIL pixel_5_3: got r=%0d g=%0d want r=5 g=3", vga_r, vga_g);
        end
      end
    end
    checks++;
    if (n_fs !== 2) begin errors++; $display("FAIL frame_start_count: got %0d want 2", n_fs); end
    checks++;
    if (n_acc !== 2 * HA * VA) begin errors++; $display("FAIL beats_accepted: got %0d want %0d", n_acc, 2 * HA * VA); end
    checks++;
    if (n_hs_low !== 2 * VT * HSY) begin errors++; $display("FAIL hs_low_cycles: got %0d want %0d", n_hs_low, 2 * VT * HSY); end
    checks++;
    if (n_vs_low !== 2 * VSY * HT) begin errors++; $display("FAIL vs_low_cycles: got %0d want %0d", n_vs_low, 2 * VSY * HT); end
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL clean_underflow: got %b want 0", underflow); end
  endtask

  task automatic test_underflow();
    do_reset();
    push_frame(); push_frame();
    run_to(8, 2);
    for (int i = 0; i < 3; i++) begin
      step(0, 0);
      void'(src.pop_front());
    end
    checks++;
    if (underflow !== 1'b1 || vga_r !== 8'd0) begin
      errors++;
      $display("FAIL underflow_gap: got uf=%b r=%0d want uf=1 r=0", underflow, vga_r);
    end
    step(0, 1);
    checks++;
    if (vga_r !== 8'(last_h) || last_h !== 11) begin
      errors++;
      $display("FAIL after_gap_pixel: got r=%0d at h=%0d want 11", vga_r, last_h);
    end
    for (int i = 0; i < FT; i++) step(0, 1);
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky: got %b want 1", underflow); end
  endtask

  task automatic test_sop_error();
    logic [3*CB-1:0] b0;
    int acc0;
    do_reset();
    push_frame();
    run_to(5, 2);
    src.delete();
    push_frame();
    b0 = src[0].data;
    acc0 = n_acc;
    step(0, 1);
    checks++;
    if (n_acc !== acc0 || {vga_r, vga_g, vga_b} !== 24'h0 || vga_blank_n !== 1'b1) begin
      errors++;
      $display("FAIL sop_error_reject: got acc+%0d rgb=%h want acc+0 rgb=0", n_acc - acc0, {vga_r, vga_g, vga_b});
    end
    run_to(0, 0);
    step(0, 1);
    checks++;
    if ({vga_r, vga_g, vga_b} !== b0 || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL sop_resume: got rgb=%h fs=%b want rgb=%h fs=1", {vga_r, vga_g, vga_b}, frame_start, b0);
    end
    for (int i = 0; i < FT; i++) step(0, 1);
  endtask

  task automatic test_seek_discard();
    beat_t b;
    logic [3*CB-1:0] b0;
    do_reset();
    for (int i = 0; i < 50; i++) begin
      b.data = 24'($urandom);
      b.sop  = 1'b0;
      src.push_back(b);
    end
    push_frame();
    b0 = src[50].data;
    clear_stats();
    for (int i = 0; i < 50; i++) step(0, 1);
    checks++;
    if (n_acc !== 50) begin errors++; $display("FAIL seek_discard: got %0d want 50", n_acc); end
    run_to(0, 0);
    checks++;
    if (n_acc !== 50 || n_fs !== 0) begin
      errors++;
      $display("FAIL sop_held: got acc=%0d fs=%0d want acc=50 fs=0", n_acc, n_fs);
    end
    step(0, 1);
    checks++;
    if ({vga_r, vga_g, vga_b} !== b0 || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL seek_lock_pixel: got rgb=%h fs=%b want rgb=%h fs=1", {vga_r, vga_g, vga_b}, frame_start, b0);
    end
  endtask

  task automatic test_midframe_reset();
    do_reset();
    push_frame(); push_frame();
    run_to(8, 3);
    step(1, 1);
    checks++;
    if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, underflow, frame_start} !== {24'h0, 5'b11000}) begin
      errors++;
      $display("FAIL midframe_reset: got %h want %h",
               {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, underflow, frame_start}, {24'h0, 5'b11000});
    end
    clear_stats();
    for (int i = 0; i < 2 * FT; i++) step(0, 1);
    checks++;
    if (n_fs !== 1 || n_hs_low !== 2 * VT * HSY || n_vs_low !== 2 * VSY * HT) begin
      errors++;
      $display("FAIL post_reset_timing: got fs=%0d hs=%0d vs=%0d want 1 %0d %0d",
               n_fs, n_hs_low, n_vs_low, 2 * VT * HSY, 2 * VSY * HT);
    end
  endtask

  task automatic test_random_stall();
    do_reset();
    push_frame(); push_frame(); push_frame();
    for (int i = 0; i < 3 * FT; i++) step(0, $urandom_range(0, 3) != 0);
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_underflow();
    test_sop_error();
    test_seek_discard();
    test_midframe_reset();
    test_random_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
